// File: rtl/head_extractor_pkg.sv
// Shared types and default sizing for the header extractor.
// The header-beat record describes one header slot update.
package head_pkg;

  localparam int DSIZE  = 4;
  localparam int HDSIZE = 8;

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    BODY
  } e_hx_state;

  typedef struct packed {
    logic [DSIZE-1:0] idata;
    logic             valid;
  } s_head_p;

endpackage

// File: rtl/head_extractor_if.sv
// Beat input, header output and payload output bundle for head_extractor.
// slave is the extractor's view of the bundle; master is the view of the surrounding logic.
interface head_extractor_if #(
  parameter int DSIZE  = head_pkg::DSIZE,
  parameter int HDSIZE = head_pkg::HDSIZE
);
  localparam int CW = $clog2(HDSIZE + 1);

  logic [DSIZE-1:0]        in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [DSIZE*HDSIZE-1:0] out_head;
  logic [CW-1:0]           out_cnt;
  logic                    out_short;
  logic                    out_valid;
  logic                    out_ready;
  logic [DSIZE-1:0]        payload_data;
  logic                    payload_valid;
  logic                    payload_last;
  logic                    payload_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready, payload_ready,
    output in_ready, out_head, out_cnt, out_short, out_valid,
           payload_data, payload_valid, payload_last
  );

  modport master (
    output in_data, in_valid, in_last, out_ready, payload_ready,
    input  in_ready, out_head, out_cnt, out_short, out_valid,
           payload_data, payload_valid, payload_last
  );

endinterface

// File: rtl/head_extractor.sv
// Collects the first HDSIZE beats of a packet into a parallel header word,
// then passes the rest of the packet combinationally to the payload port.
module head_extractor
  import head_pkg::*;
#(
  parameter int DSIZE     = head_pkg::DSIZE,
  parameter int HDSIZE    = head_pkg::HDSIZE,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clock,
  input logic             rst_n,
  head_extractor_if.slave bus
);

  localparam int CW = $clog2(HDSIZE + 1);

  e_hx_state               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    started_q, started_d;
  logic                    short_q, short_d;
  logic                    body_pending_q, body_pending_d;
  logic [DSIZE*HDSIZE-1:0] head_q;
  logic [CW-1:0]           idx;
  logic                    collect_accept;
  s_head_p                 slot_d [HDSIZE];

  // cnt_q keeps the finished header's count visible until the next packet starts,
  // so the write index is forced to 0 for the first beat of each packet.
  assign idx            = started_q ? cnt_q : '0;
  assign collect_accept = (state_q == COLLECT) && bus.in_valid;

  for (genvar gi = 0; gi < HDSIZE; gi++) begin : g_slot
    localparam int BEAT = MSB_FIRST ? (HDSIZE - 1 - gi) : gi;
    logic hit;
    assign hit        = collect_accept && (idx == CW'(BEAT));
    // The first beat also clears every other slot so no stale header data survives.
    assign slot_d[gi] = '{idata: (hit ? bus.in_data : '0),
                          valid: (collect_accept && (hit || !started_q))};
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    started_d         = started_q;
    short_d           = short_q;
    body_pending_d    = body_pending_q;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
    bus.payload_data  = '0;

    case (state_q)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_d     = idx + CW'(1);
          started_d = 1'b1;
          if (idx == CW'(HDSIZE - 1)) begin
            state_d        = HOLD;
            short_d        = 1'b0;
            body_pending_d = ~bus.in_last;
            started_d      = 1'b0;
          end else if (bus.in_last) begin
            state_d        = HOLD;
            short_d        = 1'b1;
            body_pending_d = 1'b0;
            started_d      = 1'b0;
          end
        end
      end

      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = body_pending_q ? BODY : COLLECT;
        end
      end

      BODY: begin
        bus.payload_data  = bus.in_data;
        bus.payload_valid = bus.in_valid;
        bus.payload_last  = bus.in_last;
        bus.in_ready      = bus.payload_ready;
        if (bus.in_valid && bus.payload_ready && bus.in_last) begin
          state_d = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      started_q      <= 1'b0;
      short_q        <= 1'b0;
      body_pending_q <= 1'b0;
      head_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      started_q      <= started_d;
      short_q        <= short_d;
      body_pending_q <= body_pending_d;
      for (int i = 0; i < HDSIZE; i++) begin
        if (slot_d[i].valid) begin
          head_q[i*DSIZE +: DSIZE] <= slot_d[i].idata;
        end
      end
    end
  end

  assign bus.out_head  = head_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_short = short_q;

endmodule

// File: tb/tb_head_extractor.sv
// Directed scoreboard bench: one extractor per slot ordering, both fed the same beats.
// Expected headers and payload beats are queued at drive time and popped on each handshake.
module tb_head_extractor;
  import head_pkg::*;

  localparam int DW = 4;
  localparam int HW = 8;
  localparam int CW = $clog2(HW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, out_ready, payload_ready;
  bit            toggle_pr;

  head_extractor_if #(.DSIZE(DW), .HDSIZE(HW)) if_msb ();
  head_extractor_if #(.DSIZE(DW), .HDSIZE(HW)) if_lsb ();

  assign if_msb.in_data       = in_data;
  assign if_msb.in_valid      = in_valid;
  assign if_msb.in_last       = in_last;
  assign if_msb.out_ready     = out_ready;
  assign if_msb.payload_ready = payload_ready;
  assign if_lsb.in_data       = in_data;
  assign if_lsb.in_valid      = in_valid;
  assign if_lsb.in_last       = in_last;
  assign if_lsb.out_ready     = out_ready;
  assign if_lsb.payload_ready = payload_ready;

  head_extractor #(.DSIZE(DW), .HDSIZE(HW), .MSB_FIRST(1'b1)) u_msb (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (if_msb)
  );

  head_extractor #(.DSIZE(DW), .HDSIZE(HW), .MSB_FIRST(1'b0)) u_lsb (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (if_lsb)
  );

  typedef struct packed {
    logic [31:0]   msb;
    logic [31:0]   lsb;
    logic [CW-1:0] cnt;
    logic          short_f;
  } hdr_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } pay_t;

  hdr_t hdr_q[$];
  pay_t pay_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic hdr_t model(input logic [DW-1:0] b[16], input int n);
    hdr_t h;
    h.msb = '0;
    h.lsb = '0;
    for (int k = 0; k < n && k < HW; k++) begin
      h.msb = h.msb | (32'(b[k]) << (DW * (HW - 1 - k)));
      h.lsb = h.lsb | (32'(b[k]) << (DW * k));
    end
    h.cnt     = (n >= HW) ? CW'(HW) : CW'(n);
    h.short_f = (n < HW);
    return h;
  endfunction

  // Scoreboard side: pop on every header or payload handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_msb.out_valid && out_ready) begin
        chk("hdr_expected", 32'(hdr_q.size() != 0), 32'd1);
        if (hdr_q.size() != 0) begin
          hdr_t h;
          h = hdr_q.pop_front();
          chk("head_msb", if_msb.out_head, h.msb);
          chk("head_lsb", if_lsb.out_head, h.lsb);
          chk("cnt", 32'(if_msb.out_cnt), 32'(h.cnt));
          chk("short", 32'(if_msb.out_short), 32'(h.short_f));
          chk("lsb_valid", 32'(if_lsb.out_valid), 32'd1);
          $display("hdr  msb=%08h lsb=%08h cnt=%0d short=%0d",
                   if_msb.out_head, if_lsb.out_head, if_msb.out_cnt, if_msb.out_short);
        end
      end
      if ((if_msb.payload_valid || if_lsb.payload_valid) && payload_ready) begin
        chk("pay_expected", 32'(pay_q.size() != 0), 32'd1);
        if (pay_q.size() != 0) begin
          pay_t p;
          p = pay_q.pop_front();
          chk("pay_data_msb", 32'(if_msb.payload_data), 32'(p.d));
          chk("pay_last_msb", 32'(if_msb.payload_last), 32'(p.l));
          chk("pay_data_lsb", 32'(if_lsb.payload_data), 32'(p.d));
          chk("pay_valid_lsb", 32'(if_lsb.payload_valid), 32'd1);
          $display("pay  data=%0h last=%0d", if_msb.payload_data, if_msb.payload_last);
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit accepted;
    int guard;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    guard    = 0;
    accepted = 1'b0;
    while (!accepted) begin
      @(negedge clk);
      if (if_msb.payload_valid) begin
        chk("in_ready_mirror", 32'(if_msb.in_ready), 32'(payload_ready));
      end
      accepted = if_msb.in_ready;
      @(posedge clk);
      #1;
      if (toggle_pr) payload_ready = ~payload_ready;
      guard++;
      if (!accepted && guard > 50) begin
        n_checks++;
        n_fail++;
        $error("FAIL beat_timeout: observed in_ready 0 for %0d cycles expected acceptance", guard);
        accepted = 1'b1;
      end
    end
  endtask

  task automatic send_pkt(input logic [DW-1:0] b[16], input int n);
    hdr_q.push_back(model(b, n));
    for (int k = HW; k < n; k++) pay_q.push_back('{d: b[k], l: (k == n - 1)});
    for (int k = 0; k < n; k++) send_beat(b[k], (k == n - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] b[16];
    rst_n         = 1'b0;
    in_data       = '0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    out_ready     = 1'b1;
    payload_ready = 1'b1;
    toggle_pr     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(if_msb.out_valid), 32'd0);
    chk("rst_out_head", if_msb.out_head, 32'h0);
    chk("rst_out_cnt", 32'(if_msb.out_cnt), 32'd0);
    chk("rst_out_short", 32'(if_msb.out_short), 32'd0);
    chk("rst_pay_valid", 32'(if_msb.payload_valid), 32'd0);
    chk("rst_in_ready", 32'(if_msb.in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full header followed by two payload beats.
    for (int i = 0; i < 16; i++) b[i] = DW'(i + 1);
    send_pkt(b, 10);
    idle(3);

    // Short packet: no payload at all.
    send_pkt(b, 3);
    idle(3);

    // Exactly HW beats, then a short packet to prove stale slots are cleared.
    send_pkt(b, 8);
    idle(2);
    b[0] = 4'hA; b[1] = 4'hB; b[2] = 4'hC;
    send_pkt(b, 3);
    idle(3);

    // Header consumer stalls for 5 cycles.
    for (int i = 0; i < 16; i++) b[i] = DW'(i + 1);
    out_ready = 1'b0;
    send_pkt(b, 8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(if_msb.out_valid), 32'd1);
      chk("hold_in_ready", 32'(if_msb.in_ready), 32'd0);
      chk("hold_head_msb", if_msb.out_head, 32'h12345678);
      chk("hold_head_lsb", if_lsb.out_head, 32'h87654321);
    end
    fork
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 16; i++) b[i] = DW'(i + 3);
    send_pkt(b, 9);
    idle(3);

    // Payload consumer toggles ready every cycle.
    for (int i = 0; i < 8; i++) b[i] = DW'(i + 1);
    b[8] = 4'hB; b[9] = 4'hC; b[10] = 4'hD; b[11] = 4'hE;
    toggle_pr = 1'b1;
    send_pkt(b, 12);
    toggle_pr     = 1'b0;
    payload_ready = 1'b1;
    idle(3);

    // Reset while the payload is streaming.
    for (int i = 0; i < 16; i++) b[i] = DW'(i + 1);
    hdr_q.push_back(model(b, 8));
    pay_q.push_back('{d: 4'h9, l: 1'b0});
    for (int k = 0; k < 9; k++) send_beat(b[k], 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(if_msb.out_valid), 32'd0);
    chk("mid_rst_out_head", if_msb.out_head, 32'h0);
    chk("mid_rst_out_cnt", 32'(if_msb.out_cnt), 32'd0);
    chk("mid_rst_out_short", 32'(if_msb.out_short), 32'd0);
    chk("mid_rst_pay_valid", 32'(if_msb.payload_valid), 32'd0);
    chk("mid_rst_pay_data", 32'(if_msb.payload_data), 32'd0);
    chk("mid_rst_in_ready", 32'(if_msb.in_ready), 32'd1);
    @(posedge clk);
    #1;
    b[0] = 4'h5; b[1] = 4'h6; b[2] = 4'h7;
    send_pkt(b, 3);
    idle(5);

    chk("hdr_queue_drained", 32'(hdr_q.size()), 32'd0);
    chk("pay_queue_drained", 32'(pay_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/head_extractor.md
Name: head_extractor

Overview:
- Splits an incoming nibble-style beat stream into a fixed-size header word plus a payload stream.
- Collects the first HDSIZE beats of each packet (DSIZE bits each) into one parallel header and presents it with a valid/ready handshake. All following beats of the packet pass through to a payload port.
- Generalises the fixed 4-bit/8-entry head record into a parametrised block. Adds short-packet detection and slot ordering.
- Sits between a serial receive front end and the header decode logic.

Parameters:
- DSIZE, 4, width of one input beat.
- HDSIZE, 8, number of beats that form one header.
- MSB_FIRST, 1, 1: first beat lands in the top slot of out_head; 0: first beat lands in slot 0 (LSBs).

Ports:
- clock  input  1  single system clock.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  DSIZE  input beat.
- in_valid  input  1  beat valid.
- in_last  input  1  last beat of packet.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- out_head  output  DSIZE*HDSIZE  assembled header.
- out_cnt  output  $clog2(HDSIZE+1)  number of beats captured into out_head.
- out_short  output  1  packet ended before HDSIZE beats.
- out_valid  output  1  header valid.
- out_ready  input  1  header consumer ready.
- payload_data  output  DSIZE  payload beat.
- payload_valid  output  1  payload valid.
- payload_last  output  1  last payload beat.
- payload_ready  input  1  payload consumer ready.

Behaviour:
- Reset, on rising clock with rst_n=0:
  - State goes to COLLECT.
  - out_head, out_cnt, out_short, out_valid go to 0; the internal body_pending flag goes to 0.
  - Reset overrides any state, including mid-HOLD and mid-BODY. Beats in flight are discarded.
- COLLECT:
  - in_ready=1, out_valid=0, payload_valid=0.
  - An accepted beat is written to slot cnt. With MSB_FIRST=1 the slot index is HDSIZE-1-cnt. Then cnt increments.
  - Accepted beat with in_last=1 while cnt<HDSIZE-1: go to HOLD with out_short=1 and body_pending=0. Slots never written read 0.
  - Accepted beat at cnt==HDSIZE-1: go to HOLD with out_short=0 and body_pending=~in_last.
  - The first beat of every packet clears all slots to 0 in the same cycle it writes slot 0. No stale data carries over from the previous header.
- HOLD:
  - out_valid=1 and in_ready=0. out_head, out_cnt and out_short are stable.
  - On out_valid & out_ready, go to BODY if body_pending is set, else go to COLLECT.
  - Header latency: out_valid asserts the cycle after the completing beat is accepted.
- BODY:
  - Combinational pass-through: payload_data=in_data, payload_valid=in_valid, payload_last=in_last, in_ready=payload_ready.
  - out_valid=0. Zero-cycle latency.
  - On an accepted beat with in_last=1, go to COLLECT.
- Outside BODY, payload_valid=0, payload_last=0 and payload_data=0.
- out_cnt is held from the completing beat until the next packet's first beat.
- No back-to-back header overlap: the next packet is not accepted until the header handshake completes. One bubble cycle minimum between packets.
- in_valid=0 in any state stalls without changing state.
- HDSIZE=1 is legal. The first beat completes the header immediately.

Decomposition:
- Shared package head_pkg holds:
  - Default parameters HDSIZE=8 and DSIZE=4.
  - State enum e_hx_state {COLLECT, HOLD, BODY}.
  - A parametrised header-beat record s_head_p, with fields idata[DSIZE] and valid, sized by the package parameters.
- No sub-module is needed. Slot write and clear logic is a single generate loop inside head_extractor.

Test Plan (DSIZE=4, HDSIZE=8):
- MSB_FIRST=1; beats 1,2,3,4,5,6,7,8,9,A with last on A -> out_head=32'h12345678, out_cnt=8, out_short=0; then payload 9,A with payload_last on A.
- 3-beat packet 1,2,3 with last on 3 -> out_head=32'h12300000, out_cnt=3, out_short=1; payload_valid never asserts; returns to COLLECT.
- MSB_FIRST=0; exactly 8 beats 1..8 with last on 8 -> out_head=32'h87654321, out_short=0; no payload; next packet is collected cleanly with stale slots zeroed.
- out_ready held low 5 cycles in HOLD -> out_valid stays 1, in_ready=0, out_head stable; the following packet is not lost or corrupted.
- In BODY, payload_ready toggles 1,0,1,0 -> in_ready mirrors it exactly; every payload beat appears once, in order.
- rst_n=0 for one cycle mid-BODY -> the next cycle has all outputs 0 and state COLLECT; a new packet 5,6,7 (last) gives out_head=32'h56700000 on default MSB_FIRST=1.
